// File: rtl/wptr_full_tmr.sv
// wptr_full_tmr: write-side pointer, full and level logic of an async FIFO.
// Pointers are triplicated, majority-voted and scrubbed every cycle.
module wptr_full_tmr #(
   parameter int ASIZE        = 3,
   parameter int AFULL_THRESH = 6,
   parameter int ECNT_W       = 8
) (
   input  logic              wclk,
   input  logic              wrst,
   input  logic              winc,
   input  logic [ASIZE:0]    wq2_rptr,
   input  logic              clr_err,
   output logic [ASIZE-1:0]  waddr,
   output logic [ASIZE:0]    wptr,
   output logic              wfull,
   output logic              walmost_full,
   output logic [ASIZE:0]    wlevel,
   output logic              woverflow,
   output logic              seu_err,
   output logic [ECNT_W-1:0] seu_err_cnt
);
   localparam int PW = ASIZE + 1;
   localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

   logic [PW-1:0] wbin0, wbin1, wbin2;
   logic [PW-1:0] wgray0, wgray1, wgray2;
   logic [PW-1:0] wbin_v, wgray_v;
   logic [PW-1:0] wbinnext, wgraynext;
   logic [PW-1:0] rbin, lvlnext, full_cmp;
   logic          wen, upset;

   // Vote the copies, form the next pointer and decode the read pointer
   always_comb begin
      wbin_v    = (wbin0 & wbin1) | (wbin0 & wbin2) | (wbin1 & wbin2);
      wgray_v   = (wgray0 & wgray1) | (wgray0 & wgray2) | (wgray1 & wgray2);
      wen       = winc & ~wfull;
      wbinnext  = wbin_v + {{ASIZE{1'b0}}, wen};
      wgraynext = (wbinnext >> 1) ^ wbinnext;
      rbin      = '0;
      for (int i = 0; i < PW; i++) begin
         rbin[i] = ^(wq2_rptr >> i);
      end
      lvlnext   = wbinnext - rbin;
      full_cmp  = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
      upset     = |((wbin0 ^ wbin1) | (wbin0 ^ wbin2) |
                    (wgray0 ^ wgray1) | (wgray0 ^ wgray2));
   end

   assign waddr = wbin_v[ASIZE-1:0];
   assign wptr  = wgray_v;

   // All three copies reload the voted/incremented value, scrubbing upsets
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin0  <= '0;
         wbin1  <= '0;
         wbin2  <= '0;
         wgray0 <= '0;
         wgray1 <= '0;
         wgray2 <= '0;
      end else begin
         wbin0  <= wbinnext;
         wbin1  <= wbinnext;
         wbin2  <= wbinnext;
         wgray0 <= wgraynext;
         wgray1 <= wgraynext;
         wgray2 <= wgraynext;
      end
   end

   // Registered full, almost-full and fill level from the next pointer
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
      end else begin
         wfull        <= (wgraynext == full_cmp);
         walmost_full <= (lvlnext >= THRESH);
         wlevel       <= lvlnext;
      end
   end

   // Sticky overflow and upset reporting; a new event beats a clear
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         woverflow   <= 1'b0;
         seu_err     <= 1'b0;
         seu_err_cnt <= '0;
      end else begin
         if (winc && wfull) begin
            woverflow <= 1'b1;
         end else if (clr_err) begin
            woverflow <= 1'b0;
         end
         seu_err <= upset;
         if (upset) begin
            if (clr_err) begin
               seu_err_cnt <= ECNT_W'(1);
            end else if (!(&seu_err_cnt)) begin
               seu_err_cnt <= seu_err_cnt + ECNT_W'(1);
            end
         end else if (clr_err) begin
            seu_err_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full_tmr.sv
// tb_wptr_full_tmr: random and directed stimulus for wptr_full_tmr,
// checked against a fill-level model of the FIFO write side.
module tb_wptr_full_tmr;
   localparam int A    = 3;
   localparam int PW   = A + 1;
   localparam int D    = 8;
   localparam int M    = 16;
   localparam int TH   = 6;
   localparam int MAX1 = 255;
   localparam int MAX2 = 3;

   logic          wclk = 1'b0;
   logic          wrst = 1'b1;
   logic          winc = 1'b0;
   logic          clr_err = 1'b0;
   logic [A:0]    wq2_rptr;
   logic [A-1:0]  waddr, waddr2;
   logic [A:0]    wptr, wptr2, wlevel, wlevel2;
   logic          wfull, wfull2, walmost_full, walmost_full2;
   logic          woverflow, woverflow2, seu_err, seu_err2;
   logic [7:0]    seu_err_cnt;
   logic [1:0]    seu_err_cnt2;
   logic [A:0]    fv1, fv2;

   int  checks = 0;
   int  errors = 0;
   int  rb = 0;
   bit  inj1 = 0;
   bit  inj2 = 0;

   int  mw = 0;
   int  mlevel = 0;
   int  mcnt1 = 0;
   int  mcnt2 = 0;
   bit  mfull = 0;
   bit  mafull = 0;
   bit  movf = 0;
   bit  merr1 = 0;
   bit  merr2 = 0;

   always #5 wclk = ~wclk;

   function automatic logic [A:0] gray(input int v);
      logic [A:0] b;
      b = PW'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic int lvl_of(input int w, input int r);
      return (w - r + M) % M;
   endfunction

   function automatic int cnt_next(input int c, input bit ev,
                                   input bit clr, input int mx);
      if (ev) return clr ? 1 : ((c == mx) ? mx : c + 1);
      return clr ? 0 : c;
   endfunction

   assign wq2_rptr = gray(rb);

   wptr_full_tmr #(.ASIZE(A), .AFULL_THRESH(TH), .ECNT_W(8)) dut (
      .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
      .clr_err(clr_err), .waddr(waddr), .wptr(wptr), .wfull(wfull),
      .walmost_full(walmost_full), .wlevel(wlevel),
      .woverflow(woverflow), .seu_err(seu_err),
      .seu_err_cnt(seu_err_cnt)
   );

   wptr_full_tmr #(.ASIZE(A), .AFULL_THRESH(TH), .ECNT_W(2)) dut2 (
      .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
      .clr_err(clr_err), .waddr(waddr2), .wptr(wptr2), .wfull(wfull2),
      .walmost_full(walmost_full2), .wlevel(wlevel2),
      .woverflow(woverflow2), .seu_err(seu_err2),
      .seu_err_cnt(seu_err_cnt2)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one write per accepted winc, level = written - read (mod 2^(A+1))
   always @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         mw     <= 0;
         mlevel <= 0;
         mfull  <= 0;
         mafull <= 0;
         movf   <= 0;
         merr1  <= 0;
         merr2  <= 0;
         mcnt1  <= 0;
         mcnt2  <= 0;
      end else begin
         mw     <= (mw + ((winc && !mfull) ? 1 : 0)) % M;
         mlevel <= lvl_of((mw + ((winc && !mfull) ? 1 : 0)) % M, rb);
         mfull  <= lvl_of((mw + ((winc && !mfull) ? 1 : 0)) % M, rb) == D;
         mafull <= lvl_of((mw + ((winc && !mfull) ? 1 : 0)) % M, rb) >= TH;
         movf   <= (winc && mfull) ? 1'b1 : (clr_err ? 1'b0 : movf);
         merr1  <= inj1;
         merr2  <= inj2;
         mcnt1  <= cnt_next(mcnt1, inj1, clr_err, MAX1);
         mcnt2  <= cnt_next(mcnt2, inj2, clr_err, MAX2);
      end
   end

   // Every cycle, both instances against the model
   always @(negedge wclk) begin
      chk("waddr", int'(waddr), mw % D);
      chk("wptr", int'(wptr), int'(gray(mw)));
      chk("wfull", int'(wfull), int'(mfull));
      chk("wlevel", int'(wlevel), mlevel);
      chk("walmost_full", int'(walmost_full), int'(mafull));
      chk("woverflow", int'(woverflow), int'(movf));
      chk("seu_err", int'(seu_err), int'(merr1));
      chk("seu_err_cnt", int'(seu_err_cnt), mcnt1);
      chk("waddr2", int'(waddr2), mw % D);
      chk("wptr2", int'(wptr2), int'(gray(mw)));
      chk("wfull2", int'(wfull2), int'(mfull));
      chk("wlevel2", int'(wlevel2), mlevel);
      chk("walmost_full2", int'(walmost_full2), int'(mafull));
      chk("woverflow2", int'(woverflow2), int'(movf));
      chk("seu_err2", int'(seu_err2), int'(merr2));
      chk("seu_err_cnt2", int'(seu_err_cnt2), mcnt2);
   end

   task automatic cyc(input bit inc, input bit clr);
      winc    = inc;
      clr_err = clr;
      @(negedge wclk);
   endtask

   // Upset one copy for one cycle: bin copy of dut, or Gray copy of dut2
   task automatic inject(input bit which, input bit clr);
      winc    = 1'b0;
      clr_err = clr;
      if (!which) begin
         fv1  = PW'(mw) ^ 4'b0010;
         force dut.wbin1 = fv1;
         inj1 = 1'b1;
      end else begin
         fv2  = gray(mw) ^ 4'b0001;
         force dut2.wgray2 = fv2;
         inj2 = 1'b1;
      end
      #1;
      chk("seu_mask_waddr", int'(waddr), mw % D);
      chk("seu_mask_wptr2", int'(wptr2), int'(gray(mw)));
      @(posedge wclk);
      #1;
      inj1 = 1'b0;
      inj2 = 1'b0;
      if (!which) begin
         fv1 = PW'(mw);
         force dut.wbin1 = fv1;
         release dut.wbin1;
      end else begin
         fv2 = gray(mw);
         force dut2.wgray2 = fv2;
         release dut2.wgray2;
      end
      @(negedge wclk);
   endtask

   initial begin
      repeat (3) @(negedge wclk);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_wptr", int'(wptr), 0);
      chk("rst_wlevel", int'(wlevel), 0);
      chk("rst_wfull", int'(wfull), 0);
      wrst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         chk("fill_waddr", int'(waddr), i);
         cyc(1'b1, 1'b0);
         chk("fill_afull", int'(walmost_full), (i >= 5) ? 1 : 0);
      end
      chk("fill_wfull", int'(wfull), 1);
      chk("fill_wlevel", int'(wlevel), 8);
      chk("fill_wptr", int'(wptr), 12);
      chk("fill_waddr_wrap", int'(waddr), 0);

      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b0);
         chk("ovf_waddr", int'(waddr), 0);
         chk("ovf_wptr", int'(wptr), 12);
         chk("ovf_set", int'(woverflow), 1);
      end
      cyc(1'b0, 1'b0);
      chk("ovf_sticky", int'(woverflow), 1);
      cyc(1'b0, 1'b1);
      chk("ovf_clr", int'(woverflow), 0);

      rb = 1;
      cyc(1'b0, 1'b0);
      chk("read_wfull", int'(wfull), 0);
      chk("read_wlevel", int'(wlevel), 7);
      rb = 2;
      cyc(1'b1, 1'b0);
      chk("net_wlevel", int'(wlevel), 7);
      for (int i = 0; i < 20; i++) begin
         rb = (rb + 1) % M;
         cyc(1'b1, 1'b0);
         chk("wrap_wfull", int'(wfull), 0);
         chk("wrap_wlevel", int'(wlevel), 7);
      end

      inject(1'b0, 1'b0);
      chk("seu_pulse", int'(seu_err), 1);
      chk("seu_cnt", int'(seu_err_cnt), 1);
      chk("seu_waddr", int'(waddr), 5);
      cyc(1'b0, 1'b0);
      chk("seu_once", int'(seu_err), 0);
      chk("seu_scrub", int'(dut.wbin0 == dut.wbin1 &&
                            dut.wbin1 == dut.wbin2), 1);

      for (int k = 1; k <= 5; k++) begin
         inject(1'b1, 1'b0);
         chk("sat_cnt2", int'(seu_err_cnt2), (k > 3) ? 3 : k);
         cyc(1'b0, 1'b0);
      end
      inject(1'b1, 1'b1);
      chk("clr_vs_seu_cnt2", int'(seu_err_cnt2), 1);
      chk("clr_cnt1", int'(seu_err_cnt), 0);

      winc = 1'b1;
      repeat (3) @(posedge wclk);
      #2;
      wrst = 1'b1;
      rb   = 0;
      #1;
      chk("arst_waddr", int'(waddr), 0);
      chk("arst_wptr", int'(wptr), 0);
      chk("arst_wfull", int'(wfull), 0);
      chk("arst_wlevel", int'(wlevel), 0);
      chk("arst_afull", int'(walmost_full), 0);
      chk("arst_ovf", int'(woverflow), 0);
      chk("arst_cnt2", int'(seu_err_cnt2), 0);
      @(negedge wclk);
      @(negedge wclk);
      wrst = 1'b0;
      chk("rel_waddr", int'(waddr), 0);
      cyc(1'b1, 1'b0);
      chk("rel_first", int'(waddr), 1);
      chk("rel_level", int'(wlevel), 1);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            inject(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
         end else begin
            if (lvl_of(mw, rb) > 0 &&
                $urandom_range(0, 99) < 45) begin
               rb = (rb + 1) % M;
            end
            cyc($urandom_range(0, 99) < ((n < 200) ? 60 : 35),
                $urandom_range(0, 19) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
